// File: rtl/mem_arbiter.sv
// Purpose : shares the single-port main memory between instruction fetch (IF, read-only)
//           and load/store (LS, read/write); one access in flight at a time.
// Latency : gnt in the request cycle N; completion (rvalid) at N+3 for a read, N+2 for a write, N+1 for address 0.
// Backpr. : requests are held off (no gnt) while an access is in flight; a requester holds req until gnt.
//
// Ports
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   if_req/if_addr -> if_gnt         IF read request / grant pulse
//   if_rvalid/if_rdata/if_err        IF completion pulse, read data (held), address-0 error
//   ls_req/ls_we/ls_addr/ls_wdata    LS request (we=1 write)
//   ls_gnt/ls_rvalid/ls_rdata/ls_err LS grant pulse, completion pulse, read data (0 after a write), error
//   mem_read/mem_write/mem_addr      registered memory strobes and address
//   mem_data                         bidirectional memory data, driven only in CMD of a write
//   busy                             high in any state other than IDLE
//
// Configuration macro: MEM_ARB_RR_EN
//   undefined : fixed priority, LS wins contention.
//   defined   : round-robin on contention using a last-owner flop (reset = IF).

module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic              own_ls;     // owner of the access in flight (1 = LS)
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic              pick_ls;    // arbitration result, valid while in IDLE
    logic              grant_ok;
    logic              g_any;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;

    logic              cmp_fire;   // completion happens at the end of this cycle
    logic              cmp_ls;
    logic [DATA_W-1:0] cmp_data;
    logic              cmp_err;

`ifdef MEM_ARB_RR_EN
    logic last_ls;                 // owner of the most recent grant (1 = LS)

    // Contention alternates away from the last owner; a lone requester always wins.
    always_comb begin
        pick_ls = ls_req;
        if (if_req && ls_req) begin
            pick_ls = !last_ls;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls <= 1'b0;
        end else if (g_any) begin
            last_ls <= pick_ls;
        end
    end
`else
    always_comb begin
        pick_ls = ls_req;
    end
`endif

    // Grant is combinational in IDLE so the requester sees it in its request cycle.
    assign grant_ok = !rst && (state == S_IDLE);
    assign if_gnt   = grant_ok && if_req && !pick_ls;
    assign ls_gnt   = grant_ok && ls_req && pick_ls;
    assign g_any    = if_gnt || ls_gnt;
    assign g_we     = pick_ls && ls_we;
    assign g_addr   = pick_ls ? ls_addr : if_addr;

    assign busy     = (state != S_IDLE);

    // Bus is driven only while the write strobe is up.
    assign mem_data = (state == S_CMD && we_q) ? wdata_q : {DATA_W{1'bz}};

    // Which cycle ends an access, and with what data/err.
    always_comb begin
        cmp_fire = 1'b0;
        cmp_ls   = own_ls;
        cmp_data = '0;
        cmp_err  = 1'b0;
        case (state)
            S_IDLE: begin
                // Address 0 is rejected straight from IDLE without touching memory.
                if (g_any && g_addr == '0) begin
                    cmp_fire = 1'b1;
                    cmp_ls   = pick_ls;
                    cmp_err  = 1'b1;
                end
            end
            S_CMD: begin
                cmp_fire = we_q;
            end
            S_WAIT: begin
                // Memory's registered read data is on the bus during this cycle.
                cmp_fire = 1'b1;
                cmp_data = mem_data;
            end
            S_DONE: begin
                cmp_fire = 1'b0;
            end
            default: begin
                cmp_fire = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            own_ls    <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (g_any) begin
                        own_ls  <= pick_ls;
                        we_q    <= g_we;
                        wdata_q <= ls_wdata;
                        if (g_addr == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_CMD;
                            mem_addr  <= g_addr;
                            mem_read  <= !g_we;
                            mem_write <= g_we;
                        end
                    end
                end
                S_CMD: begin
                    state <= we_q ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // rdata only changes on a completion to that port, so it holds otherwise.
            if (cmp_fire) begin
                if (cmp_ls) begin
                    ls_rvalid <= 1'b1;
                    ls_rdata  <= cmp_data;
                    ls_err    <= cmp_err;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= cmp_data;
                    if_err    <= cmp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter with a transaction-level reference model.
// Latency : n/a (bench).
// Backpr. : requester tasks hold req until gnt, or give up after a chosen number of cycles.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [15:0] if_rdata;

    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [15:0] ls_wdata = '0;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [15:0] ls_rdata;

    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .ls_err   (ls_err),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // ---------------- main memory: one-cycle registered read ----------------
    logic [15:0] phys [logic [15:0]];
    logic [15:0] mem_q = '0;
    logic        mem_oe = 1'b0;

    assign mem_data = mem_oe ? mem_q : 16'bz;

    always @(posedge clk) begin
        mem_oe <= mem_read;
        if (mem_read) mem_q <= phys.exists(mem_addr) ? phys[mem_addr] : init_val(mem_addr);
        if (mem_write) phys[mem_addr] = mem_data;
    end

    // ---------------- reference model (transaction level) ----------------
    logic [15:0] ref_mem [logic [15:0]];
    bit          act_v = 0;
    int          act_n, act_done;
    bit          act_ls, act_we;
    logic [15:0] act_addr, act_wdata;
    logic [15:0] exp_if_rdata = '0;
    logic [15:0] exp_ls_rdata = '0;
    bit          m_last_ls = 0;

    bit glog[$];          // observed grant owners, 1 = LS
    int rd_cyc = -1, wr_cyc = -1, strobe_cnt = 0, rv_cnt = 0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        bit e_ig, e_lg, e_busy, e_rd, e_wr, e_irv, e_lrv, e_ie, e_le, w_ls;
        logic [15:0] rv;
        e_ig = 0; e_lg = 0; e_busy = 0; e_rd = 0; e_wr = 0;
        e_irv = 0; e_lrv = 0; e_ie = 0; e_le = 0; w_ls = 0; rv = '0;

        if (if_gnt) glog.push_back(1'b0);
        if (ls_gnt) glog.push_back(1'b1);
        if (mem_read) begin rd_cyc = cyc; strobe_cnt++; end
        if (mem_write) begin wr_cyc = cyc; strobe_cnt++; end
        if (if_rvalid || ls_rvalid) rv_cnt++;

        if (rst) begin
            act_v = 0;
            exp_if_rdata = '0;
            exp_ls_rdata = '0;
            m_last_ls = 0;
        end else if (act_v && cyc <= act_done) begin
            e_busy = 1;
            if (cyc == act_n + 1 && act_addr != 0) begin
                e_rd = !act_we;
                e_wr = act_we;
            end
            if (cyc == act_done) begin
                if (act_addr != 0 && act_we) ref_mem[act_addr] = act_wdata;
                else if (act_addr != 0) rv = ref_rd(act_addr);
                if (act_ls) begin e_lrv = 1; e_le = (act_addr == 0); exp_ls_rdata = rv; end
                else        begin e_irv = 1; e_ie = (act_addr == 0); exp_if_rdata = rv; end
            end
        end else if (if_req || ls_req) begin
`ifdef MEM_ARB_RR_EN
            w_ls = (if_req && ls_req) ? !m_last_ls : ls_req;
`else
            w_ls = ls_req;
`endif
            m_last_ls = w_ls;
            e_ig      = !w_ls;
            e_lg      = w_ls;
            act_v     = 1;
            act_n     = cyc;
            act_ls    = w_ls;
            act_we    = w_ls && ls_we;
            act_addr  = w_ls ? ls_addr : if_addr;
            act_wdata = ls_wdata;
            act_done  = cyc + ((act_addr == 0) ? 1 : (act_we ? 2 : 3));
        end

        chk("if_gnt", if_gnt, e_ig);
        chk("ls_gnt", ls_gnt, e_lg);
        chk("busy", busy, e_busy);
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("if_rvalid", if_rvalid, e_irv);
        chk("ls_rvalid", ls_rvalid, e_lrv);
        chk("if_err", if_err, e_ie);
        chk("ls_err", ls_err, e_le);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("ls_rdata", ls_rdata, exp_ls_rdata);
        if (e_rd || e_wr) chk("mem_addr", mem_addr, act_addr);
        if (e_wr) chk("mem_data", mem_data, act_wdata);
    end

    // ---------------- requester tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic if_op(input logic [15:0] a, input int give_up,
                         output int gc, output int vc, output logic [15:0] rd, output logic er);
        gc = -1; vc = -1; rd = '0; er = 1'b0;
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_gnt) begin gc = cyc; break; end
            if (give_up > 0 && i + 1 >= give_up) break;
        end
        step();
        if_req = 1'b0;
        if (give_up == 0) chk("if_gnt_timeout", (gc >= 0), 1);
        if (gc >= 0) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (if_rvalid) begin vc = cyc; rd = if_rdata; er = if_err; break; end
            end
            chk("if_rvalid_timeout", (vc >= 0), 1);
        end
    endtask

    task automatic ls_op(input logic we, input logic [15:0] a, input logic [15:0] d, input int give_up,
                         output int gc, output int vc, output logic [15:0] rd, output logic er);
        gc = -1; vc = -1; rd = '0; er = 1'b0;
        ls_we    = we;
        ls_addr  = a;
        ls_wdata = d;
        ls_req   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_gnt) begin gc = cyc; break; end
            if (give_up > 0 && i + 1 >= give_up) break;
        end
        step();
        ls_req = 1'b0;
        if (give_up == 0) chk("ls_gnt_timeout", (gc >= 0), 1);
        if (gc >= 0) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ls_rvalid) begin vc = cyc; rd = ls_rdata; er = ls_err; break; end
            end
            chk("ls_rvalid_timeout", (vc >= 0), 1);
        end
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int gc, vc, gc2, vc2, sc, base;
        logic [15:0] rd, rd2;
        logic er, er2;

        phys[16'h0010]    = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if_req = 1'b1; ls_req = 1'b1;
        #1;
        chk("rst_gnt", {if_gnt, ls_gnt}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        if_req = 1'b0; ls_req = 1'b0;
        rst = 1'b0;
        step();

        // Reset in the CMD cycle of an LS write.
        ls_we = 1'b1; ls_addr = 16'h0040; ls_wdata = 16'h7777; ls_req = 1'b1;
        gc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_gnt) begin gc = cyc; break; end
        end
        chk("t1_gnt_seen", (gc >= 0), 1);
        step();
        ls_req = 1'b0;
        chk("t1_cmd_write", mem_write, 1);
        rst = 1'b1;
        #1;
        chk("t1_rst_write", mem_write, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_rvalid", {if_rvalid, ls_rvalid}, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t1_idle", busy, 0);
        sc = rv_cnt;
        repeat (6) step();
        chk("t1_no_rvalid", rv_cnt, sc);
        ls_op(1'b0, 16'h0040, 16'h0, 0, gc, vc, rd, er);
        chk("t1_write_dropped", rd, 16'h5A7C);
        step();

        // IF read 0x0010.
        if_op(16'h0010, 0, gc, vc, rd, er);
        chk("t2_rd_strobe", rd_cyc, gc + 1);
        chk("t2_lat", vc - gc, 3);
        chk("t2_data", rd, 16'hBEEF);
        chk("t2_err", er, 0);
        step();

        // LS write then read back.
        ls_op(1'b1, 16'h0020, 16'h1234, 0, gc, vc, rd, er);
        chk("t3_wr_strobe", wr_cyc, gc + 1);
        chk("t3_wr_lat", vc - gc, 2);
        chk("t3_wr_rdata", rd, 0);
        step();
        ls_op(1'b0, 16'h0020, 16'h0, 0, gc, vc, rd, er);
        chk("t3_rd_lat", vc - gc, 3);
        chk("t3_rd_data", rd, 16'h1234);
        step();

        // LS read of address 0.
        sc = strobe_cnt;
        ls_op(1'b0, 16'h0000, 16'h0, 0, gc, vc, rd, er);
        chk("t4_lat", vc - gc, 1);
        chk("t4_err", er, 1);
        chk("t4_rdata", rd, 0);
        chk("t4_no_strobe", strobe_cnt, sc);
        step();

        // Make IF the last owner, then hold both requests for four accesses.
        if_op(16'h0010, 0, gc, vc, rd, er);
        chk("t5_pre_data", rd, 16'hBEEF);
        step();
        base = glog.size();
        if_addr = 16'h0050; ls_we = 1'b0; ls_addr = 16'h0060;
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 60 && glog.size() < base + 4; i++) @(negedge clk);
        step();
        if_req = 1'b0; ls_req = 1'b0;
        repeat (6) step();
        chk("t5_count", (glog.size() >= base + 4), 1);
        if (glog.size() >= base + 4) begin
`ifdef MEM_ARB_RR_EN
            chk("t5_order", {glog[base], glog[base+1], glog[base+2], glog[base+3]}, 4'b1010);
`else
            chk("t5_order", {glog[base], glog[base+1], glog[base+2], glog[base+3]}, 4'b1111);
`endif
        end

        // IF request arriving while an LS write is in flight.
        fork
            begin
                ls_op(1'b1, 16'h0070, 16'hCAFE, 0, gc, vc, rd, er);
            end
            begin
                step();
                if_op(16'h0070, 0, gc2, vc2, rd2, er2);
            end
        join
        chk("t6_if_gnt", gc2, vc + 1);
        chk("t6_if_lat", vc2 - gc2, 3);
        chk("t6_if_data", rd2, 16'hCAFE);
        step();

        // Random traffic from both requesters.
        fork
            begin
                int g, v; logic [15:0] r; logic e;
                for (int k = 0; k < 40; k++) begin
                    step();
                    repeat ($urandom_range(0, 3)) step();
                    if_op(16'($urandom_range(0, 7) << 4),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                          g, v, r, e);
                end
            end
            begin
                int g, v; logic [15:0] r; logic e;
                for (int k = 0; k < 40; k++) begin
                    step();
                    repeat ($urandom_range(0, 3)) step();
                    ls_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7) << 4),
                          16'($urandom_range(0, 65535)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                          g, v, r, e);
                end
            end
        join
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
